// File: rtl/oflow_mem_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oflow_mem_reader_pkg                                                       |
// | Shared types and constants for the oflow_MEM history read sequencer.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package oflow_mem_reader_pkg;

    localparam int c_FRAME_W  = 8;
    localparam int c_HIST_W   = 3;
    localparam int c_OFFSET_W = 7;
    localparam int c_MAX_HIST = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // A zero history depth is illegal; map it onto slot 0 rather than divide by zero.
    function automatic int unsigned slot_of(input int unsigned frame, input int unsigned h);
        return (h == 0) ? 0 : (frame % h);
    endfunction

endpackage

`default_nettype wire

// File: rtl/oflow_mem_reader_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oflow_mem_reader_fifo                                                      |
// | Two-entry FIFO for returned read beats; head reads zero when empty.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module oflow_mem_reader_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_occ;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr] <= push_data;
                r_wr        <= ~r_wr;
            end
            if (pop) begin
                r_rd <= ~r_rd;
            end
            r_occ <= r_occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = (r_occ != 2'd0) ? r_mem[r_rd] : '0;
    assign occ       = r_occ;

endmodule

`default_nettype wire

// File: rtl/oflow_mem_history_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oflow_mem_history_reader                                                   |
// | Walks stored history frames, issues dual-port reads, streams pairs out.    |
// | Option: OFLOW_MEM_READER_OLDEST_FIRST_EN walks frames oldest first.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module oflow_mem_history_reader
    import oflow_mem_reader_pkg::*;
#(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int FRAME_W    = c_FRAME_W,
    parameter int HIST_W     = c_HIST_W,
    parameter int OFFSET_W   = c_OFFSET_W
) (
    input  logic                  clk,
    input  logic                  reset_N,
    input  logic [FRAME_W-1:0]    frame_num,
    input  logic [HIST_W-1:0]     num_of_history_frames,
    input  logic                  frame_done,
    input  logic [OFFSET_W:0]     obj_count,
    input  logic                  start,
    input  logic                  mem_busy,
    output logic [FRAME_W-1:0]    mem_frame_num,
    output logic [OFFSET_W-1:0]   offset_0,
    output logic [OFFSET_W-1:0]   offset_1,
    output logic                  csb_0,
    output logic                  csb_1,
    output logic                  oeb,
    input  logic [DATA_WIDTH-1:0] data_out_0,
    input  logic [DATA_WIDTH-1:0] data_out_1,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data_0,
    output logic [DATA_WIDTH-1:0] rd_data_1,
    output logic                  rd_lane1_valid,
    output logic [HIST_W-1:0]     rd_hist_idx,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done
);

    localparam int c_CNT_W   = OFFSET_W + 1;
    localparam int c_ENTRY_W = 2 * DATA_WIDTH + HIST_W + 2;

    state_t               r_state;
    logic [FRAME_W-1:0]   r_f;
    logic [HIST_W-1:0]    r_h;
    logic [HIST_W-1:0]    r_k;
    logic [c_CNT_W-1:0]   r_o;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_inf_valid;
    logic                 r_inf_lane1;
    logic                 r_inf_last;
    logic [HIST_W-1:0]    r_inf_hist;
    logic [c_MAX_HIST-1:0] r_slot_valid;
    logic [c_CNT_W-1:0]   r_slot_cnt [0:c_MAX_HIST-1];

    logic [2:0]           w_wr_slot;
    logic [FRAME_W-1:0]   w_fr   [1:c_MAX_HIST];
    logic [2:0]           w_slot [1:c_MAX_HIST];
    logic [c_MAX_HIST:1]  w_ok;
    logic                 w_found;
    logic                 w_more;
    logic [HIST_W-1:0]    w_sel;
    logic [c_CNT_W-1:0]   w_cnt;
    logic [FRAME_W-1:0]   w_cur_fr;
    logic [c_CNT_W-1:0]   w_o;
    logic [c_CNT_W:0]     w_o1;
    logic [c_CNT_W:0]     w_o2;
    logic                 w_lane1;
    logic                 w_tail;
    logic [1:0]           w_occ;
    logic                 w_pop;
    logic [2:0]           w_room;
    logic                 w_issue;
    logic [c_ENTRY_W-1:0] w_push_data;
    logic [c_ENTRY_W-1:0] w_head;

    // Slot table: frame 0 re-partitions the buffer, so it wipes every slot.
    assign w_wr_slot = 3'(slot_of(32'(frame_num), 32'(num_of_history_frames)));

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_slot_valid <= '0;
            for (int i = 0; i < c_MAX_HIST; i++) begin
                r_slot_cnt[i] <= '0;
            end
        end else if (frame_done) begin
            if (frame_num == '0) begin
                r_slot_valid <= '0;
                for (int i = 0; i < c_MAX_HIST; i++) begin
                    r_slot_cnt[i] <= '0;
                end
            end
            if (w_wr_slot < 3'(c_MAX_HIST)) begin
                r_slot_valid[w_wr_slot] <= 1'b1;
                r_slot_cnt[w_wr_slot]   <= obj_count;
            end
        end
    end

    // Candidate frames F-j; the walk picks the first live one at or beyond r_k.
    always_comb begin
        w_found  = 1'b0;
        w_more   = 1'b0;
        w_sel    = '0;
        w_cnt    = '0;
        w_cur_fr = '0;
        for (int j = 1; j <= c_MAX_HIST; j++) begin
            w_fr[j]   = r_f - FRAME_W'(j);
            w_slot[j] = 3'(slot_of(32'(w_fr[j]), 32'(r_h)));
            w_ok[j]   = (j <= 32'(r_h)) && (j <= 32'(r_f)) && (w_slot[j] < 3'(c_MAX_HIST))
                        && r_slot_valid[w_slot[j]] && (r_slot_cnt[w_slot[j]] != '0);
        end
`ifdef OFLOW_MEM_READER_OLDEST_FIRST_EN
        for (int j = c_MAX_HIST; j >= 1; j--) begin
            if (w_found && w_ok[j]) w_more = 1'b1;
            if (!w_found && w_ok[j] && (j <= 32'(r_k))) begin
                w_found = 1'b1;
                w_sel   = HIST_W'(j);
            end
        end
`else
        for (int j = 1; j <= c_MAX_HIST; j++) begin
            if (w_found && w_ok[j]) w_more = 1'b1;
            if (!w_found && w_ok[j] && (j >= 32'(r_k))) begin
                w_found = 1'b1;
                w_sel   = HIST_W'(j);
            end
        end
`endif
        for (int j = 1; j <= c_MAX_HIST; j++) begin
            if (w_found && (HIST_W'(j) == w_sel)) begin
                w_cnt    = r_slot_cnt[w_slot[j]];
                w_cur_fr = w_fr[j];
            end
        end
    end

    assign w_o     = (w_sel == r_k) ? r_o : '0;
    assign w_o1    = {1'b0, w_o} + (c_CNT_W+1)'(1);
    assign w_o2    = {1'b0, w_o} + (c_CNT_W+1)'(2);
    assign w_lane1 = (w_o1 < {1'b0, w_cnt});
    assign w_tail  = (w_o2 >= {1'b0, w_cnt});

    // Room accounts for this cycle's pop and the beat already on its way back.
    assign w_pop   = rd_valid && rd_ready;
    assign w_room  = {1'b0, w_occ} - {2'b00, w_pop} + {2'b00, r_inf_valid};
    assign w_issue = (r_state == READ) && w_found && !mem_busy && (w_room < 3'd2);

    assign csb_0         = ~w_issue;
    assign csb_1         = ~(w_issue && w_lane1);
    assign oeb           = ~w_issue;
    assign offset_0      = w_issue ? w_o[OFFSET_W-1:0]  : '0;
    assign offset_1      = w_issue ? w_o1[OFFSET_W-1:0] : '0;
    assign mem_frame_num = w_issue ? w_cur_fr : '0;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_state     <= IDLE;
            r_f         <= '0;
            r_h         <= '0;
            r_k         <= '0;
            r_o         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_inf_valid <= 1'b0;
            r_inf_lane1 <= 1'b0;
            r_inf_last  <= 1'b0;
            r_inf_hist  <= '0;
        end else begin
            r_done      <= 1'b0;
            r_inf_valid <= w_issue;
            r_inf_lane1 <= w_lane1;
            r_inf_last  <= w_tail && !w_more;
            r_inf_hist  <= w_sel;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SETUP;
                        r_busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    r_f     <= frame_num;
                    r_h     <= num_of_history_frames;
                    r_o     <= '0;
`ifdef OFLOW_MEM_READER_OLDEST_FIRST_EN
                    r_k     <= num_of_history_frames;
`else
                    r_k     <= HIST_W'(1);
`endif
                    r_state <= READ;
                end
                READ: begin
                    if (!w_found) begin
                        r_state <= DRAIN;
                    end else if (w_issue && w_tail) begin
                        r_o <= '0;
`ifdef OFLOW_MEM_READER_OLDEST_FIRST_EN
                        r_k <= w_sel - HIST_W'(1);
`else
                        r_k <= w_sel + HIST_W'(1);
`endif
                    end else if (w_issue) begin
                        r_o <= w_o2[c_CNT_W-1:0];
                        r_k <= w_sel;
                    end else begin
                        r_o <= w_o;
                        r_k <= w_sel;
                    end
                end
                DRAIN: begin
                    if (w_room == 3'd0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_push_data = {data_out_0, (r_inf_lane1 ? data_out_1 : {DATA_WIDTH{1'b0}}),
                          r_inf_lane1, r_inf_hist, r_inf_last};

    oflow_mem_reader_fifo #(
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset_N   (reset_N),
        .push      (r_inf_valid),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head_data (w_head),
        .occ       (w_occ)
    );

    assign {rd_data_0, rd_data_1, rd_lane1_valid, rd_hist_idx, rd_last} = w_head;
    assign rd_valid = (w_occ != 2'd0);
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_oflow_mem_history_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_oflow_mem_history_reader                                                |
// | Randomized bench with a log-based history model and a memory model.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps

module tb_oflow_mem_history_reader;

    localparam int DW = 32;
    localparam int FW = 8;
    localparam int HW = 3;
    localparam int OW = 7;
`ifdef OFLOW_MEM_READER_OLDEST_FIRST_EN
    localparam bit OLDEST = 1'b1;
`else
    localparam bit OLDEST = 1'b0;
`endif
    localparam logic [32:0] c_RESET_OUTS = {3'b111, 30'd0};

    logic          clk = 1'b0;
    logic          reset_N = 1'b0;
    logic [FW-1:0] frame_num = '0;
    logic [HW-1:0] num_of_history_frames = 3'd3;
    logic          frame_done = 1'b0;
    logic [OW:0]   obj_count = '0;
    logic          start = 1'b0;
    logic          mem_busy = 1'b0;
    logic [FW-1:0] mem_frame_num;
    logic [OW-1:0] offset_0, offset_1;
    logic          csb_0, csb_1, oeb;
    logic [DW-1:0] data_out_0 = '0;
    logic [DW-1:0] data_out_1 = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic [DW-1:0] rd_data_0, rd_data_1;
    logic          rd_lane1_valid;
    logic [HW-1:0] rd_hist_idx;
    logic          rd_last, busy, done;

    always #5 clk = ~clk;

    oflow_mem_history_reader #(
        .DATA_WIDTH (DW), .FRAME_W (FW), .HIST_W (HW), .OFFSET_W (OW)
    ) dut (
        .clk (clk), .reset_N (reset_N), .frame_num (frame_num),
        .num_of_history_frames (num_of_history_frames), .frame_done (frame_done),
        .obj_count (obj_count), .start (start), .mem_busy (mem_busy),
        .mem_frame_num (mem_frame_num), .offset_0 (offset_0), .offset_1 (offset_1),
        .csb_0 (csb_0), .csb_1 (csb_1), .oeb (oeb),
        .data_out_0 (data_out_0), .data_out_1 (data_out_1),
        .rd_valid (rd_valid), .rd_ready (rd_ready), .rd_data_0 (rd_data_0),
        .rd_data_1 (rd_data_1), .rd_lane1_valid (rd_lane1_valid),
        .rd_hist_idx (rd_hist_idx), .rd_last (rd_last), .busy (busy), .done (done)
    );

    function automatic logic [DW-1:0] word(input int fr, input int off);
        return DW'(32'h5EED0000 + fr * 1031 + off * 17 + (fr ^ off));
    endfunction

    // Buffer model: registered read, data one cycle after the chip select.
    always @(posedge clk) begin
        if (!csb_0 && !oeb) data_out_0 <= word(int'(mem_frame_num), int'(offset_0));
        if (!csb_1 && !oeb) data_out_1 <= word(int'(mem_frame_num), int'(offset_1));
    end

    typedef struct packed {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          l1;
        logic [HW-1:0] hist;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    done_fr[$];
    int    done_cnt[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    done_at, last_pop_at, csb_viol, hold_viol, rdv_seen;
    bit    timed_out, busy_after_start, done_after, busy_after;

    function automatic logic [32:0] outs_now();
        return {csb_0, csb_1, oeb, offset_0, offset_1, mem_frame_num,
                rd_valid, rd_lane1_valid, rd_last, busy, done, rd_hist_idx};
    endfunction

    task automatic do_frame(input int fn, input int c);
        @(negedge clk);
        frame_num  = fn[FW-1:0];
        obj_count  = c[OW:0];
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        if (fn == 0) begin
            done_fr.delete();
            done_cnt.delete();
        end
        done_fr.push_back(fn);
        done_cnt.push_back(c);
    endtask

    // A frame is readable only if it was the latest one written to its slot.
    task automatic build_expected(input int F, input int H);
        beat_t b;
        int k, f, c;
        exp_q.delete();
        for (int n = 0; n < H; n++) begin
            k = OLDEST ? (H - n) : (n + 1);
            f = F - k;
            c = -1;
            if (k > F) continue;
            for (int i = 0; i < done_fr.size(); i++)
                if (done_fr[i] % H == f % H) c = (done_fr[i] == f) ? done_cnt[i] : -1;
            for (int o = 0; o < c; o += 2) begin
                b.d0   = word(f, o);
                b.l1   = (o + 1 < c);
                b.d1   = b.l1 ? word(f, o + 1) : '0;
                b.hist = k[HW-1:0];
                b.last = 1'b0;
                exp_q.push_back(b);
            end
        end
        if (exp_q.size() > 0) begin
            b = exp_q.pop_back();
            b.last = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    // rmode: 0 ready high, 1 ready toggling 1010, 2 ready random.
    task automatic do_request(input int F, input int rmode, input int busy_at, input int again_at);
        beat_t cur, prev;
        bit stall;
        got_q.delete();
        done_at = -1; last_pop_at = -1; csb_viol = 0; hold_viol = 0; rdv_seen = 0;
        timed_out = 1'b1; stall = 1'b0; prev = '0;
        @(negedge clk);
        frame_num = F[FW-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        busy_after_start = busy;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            rd_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            mem_busy = (busy_at >= 0) && (cyc >= busy_at) && (cyc < busy_at + 3);
            start    = (cyc == again_at);
            #1;
            cur.d0 = rd_data_0; cur.l1 = rd_lane1_valid;
            cur.d1 = rd_lane1_valid ? rd_data_1 : '0;
            cur.hist = rd_hist_idx; cur.last = rd_last;
            if (mem_busy && (!csb_0 || !csb_1)) csb_viol++;
            if (stall && (!rd_valid || cur != prev)) hold_viol++;
            if (rd_valid) rdv_seen++;
            if (done) begin
                done_at = cyc;
                timed_out = 1'b0;
                break;
            end
            stall = rd_valid && !rd_ready;
            prev  = cur;
            if (rd_valid && rd_ready) begin
                got_q.push_back(cur);
                last_pop_at = cyc;
            end
        end
        start = 1'b0; mem_busy = 1'b0; rd_ready = 1'b1;
        @(negedge clk);
        #1;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        reset_N = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (outs_now() !== c_RESET_OUTS) begin
            n_err++;
            $display("FAIL reset_in: outputs=%h want=%h", outs_now(), c_RESET_OUTS);
        end
        reset_N = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (outs_now() !== c_RESET_OUTS) begin
            n_err++;
            $display("FAIL reset_out: outputs=%h want=%h", outs_now(), c_RESET_OUTS);
        end
    endtask

    task automatic test_basic();
        num_of_history_frames = 3'd3;
        do_frame(0, 4); do_frame(1, 3); do_frame(2, 5); do_frame(3, 2);
        build_expected(4, 3);
        do_request(4, 0, -1, -1);
        n_cmp++;
        if (timed_out) begin n_err++; $display("FAIL basic_done: no done within budget"); end
        n_cmp++;
        if (busy_after_start !== 1'b1) begin n_err++; $display("FAIL basic_busy: busy=%0b want 1", busy_after_start); end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL basic_count: beats=%0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL basic_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (done_at != last_pop_at + 1) begin
            n_err++; $display("FAIL basic_done_timing: done cycle %0d want %0d", done_at, last_pop_at + 1);
        end
        n_cmp++;
        if (done_after !== 1'b0 || busy_after !== 1'b0) begin
            n_err++; $display("FAIL basic_idle: done=%0b busy=%0b want 0 0", done_after, busy_after);
        end
    endtask

    task automatic test_backpressure();
        num_of_history_frames = 3'd4;
        do_frame(0, $urandom_range(1, 9));
        for (int f = 1; f < 5; f++) do_frame(f, $urandom_range(3, 9));
        build_expected(5, 4);
        do_request(5, 1, 4, 6);
        n_cmp++;
        if (timed_out) begin n_err++; $display("FAIL bp_done: no done within budget"); end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL bp_count: beats=%0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL bp_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (csb_viol != 0) begin n_err++; $display("FAIL bp_csb_busy: %0d selects during mem_busy, want 0", csb_viol); end
        n_cmp++;
        if (hold_viol != 0) begin n_err++; $display("FAIL bp_hold: %0d unstable stalled beats, want 0", hold_viol); end
    endtask

    task automatic test_random();
        int h, n;
        for (int it = 0; it < 6; it++) begin
            h = $urandom_range(1, 5);
            n = $urandom_range(0, 7);
            num_of_history_frames = h[HW-1:0];
            for (int f = 0; f <= n; f++) do_frame(f, $urandom_range(0, 9));
            build_expected(n + 1, h);
            do_request(n + 1, 2, $urandom_range(0, 8), -1);
            n_cmp++;
            if (timed_out) begin n_err++; $display("FAIL rnd%0d_done: no done within budget", it); end
            n_cmp++;
            if (got_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL rnd%0d_count: beats=%0d want %0d (H=%0d F=%0d)", it, got_q.size(), exp_q.size(), h, n + 1);
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL rnd%0d_beat[%0d]: got %h want %h", it, i, got_q[i], exp_q[i]);
                end
            end
            n_cmp++;
            if (csb_viol != 0 || hold_viol != 0) begin
                n_err++; $display("FAIL rnd%0d_proto: csb_viol=%0d hold_viol=%0d want 0 0", it, csb_viol, hold_viol);
            end
        end
    endtask

    task automatic test_empty();
        num_of_history_frames = 3'd3;
        do_frame(0, 5);
        do_request(0, 0, -1, -1);
        n_cmp++;
        if (timed_out || rdv_seen != 0) begin
            n_err++; $display("FAIL empty_f0: timed_out=%0b rd_valid cycles=%0d want 0 0", timed_out, rdv_seen);
        end
        num_of_history_frames = 3'd2;
        do_frame(0, 0); do_frame(1, 0); do_frame(2, 0);
        do_request(3, 0, -1, -1);
        n_cmp++;
        if (timed_out || rdv_seen != 0) begin
            n_err++; $display("FAIL empty_cnt0: timed_out=%0b rd_valid cycles=%0d want 0 0", timed_out, rdv_seen);
        end
    endtask

    task automatic test_frame0_clear();
        num_of_history_frames = 3'd3;
        for (int f = 0; f < 5; f++) do_frame(f, f + 3);
        do_frame(0, 0);
        do_request(3, 0, -1, -1);
        n_cmp++;
        if (timed_out || rdv_seen != 0) begin
            n_err++; $display("FAIL f0_clear: timed_out=%0b rd_valid cycles=%0d want 0 0", timed_out, rdv_seen);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        num_of_history_frames = 3'd3;
        do_frame(0, 4); do_frame(1, 3); do_frame(2, 5); do_frame(3, 2);
        @(negedge clk);
        frame_num = 8'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            #1;
            if (!csb_0) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL rstmid_issue: no read issued within budget"); end
        reset_N = 1'b0;
        #1;
        n_cmp++;
        if (outs_now() !== c_RESET_OUTS) begin
            n_err++; $display("FAIL rstmid_outs: outputs=%h want=%h", outs_now(), c_RESET_OUTS);
        end
        repeat (2) @(negedge clk);
        reset_N = 1'b1;
        done_fr.delete();
        done_cnt.delete();
        do_frame(0, 6); do_frame(1, 1); do_frame(2, 4);
        build_expected(3, 3);
        do_request(3, 0, -1, -1);
        n_cmp++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rstmid_count: timed_out=%0b beats=%0d want %0d", timed_out, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL rstmid_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_empty();
        test_frame0_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
